alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 80 ++++++++
 tb/tb_alu_issue_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue controller sequencing decode, execute and write-back for the 16-bit ALU.
// Optional retired-instruction counter enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_ctrl #(
    parameter int N    = 16,
    parameter int RA_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [N-1:0]    instr,
    output logic            instr_ready,
    output logic [2:0]      alu_func,
    output logic [RA_W-1:0] rf_rd_addr1,
    output logic [RA_W-1:0] rf_rd_addr2,
    output logic [RA_W-1:0] rf_wr_addr,
    output logic            rf_wr_en,
    input  logic            alu_zero,
    output logic            zero_flag,
    output logic            pc_load,
    output logic [8:0]      pc_offset,
    output logic            illegal,
    output logic [15:0]     perf_retired
);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2;
    logic [1:0] state;
    logic [3:0] op;
    logic       pend;
    logic       is_alu, is_bz, is_ill, accept;
    assign is_alu = op <= 4'd5;
    assign is_bz  = op == 4'h8;
    assign is_ill = !is_alu && !is_bz && op != 4'h6;
    assign accept = state == IDLE && instr_valid;
    // Strobes are gated by rst so an aborted instruction never writes or redirects.
    assign instr_ready = state == IDLE;
    assign rf_wr_en    = state == WB && !rst;
    assign pc_load     = state == EXEC && is_bz && zero_flag && !rst;
    assign illegal     = state == EXEC && is_ill && !rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op          <= 4'h6;
            pend        <= 1'b0;
            zero_flag   <= 1'b0;
            alu_func    <= 3'b110;
            rf_rd_addr1 <= '0;
            rf_rd_addr2 <= '0;
            rf_wr_addr  <= '0;
            pc_offset   <= '0;
        end else if (accept) begin
            state       <= EXEC;
            op          <= instr[15:12];
            alu_func    <= instr[15:12] <= 4'd5 ? instr[14:12] : 3'b110;
            rf_rd_addr1 <= instr[11:9];
            rf_rd_addr2 <= instr[8:6];
            rf_wr_addr  <= instr[11:9];
            pc_offset   <= instr[8:0];
        end else if (state == EXEC) begin
            pend  <= alu_zero;
            state <= is_alu ? WB : IDLE;
            if (!is_alu)
                alu_func <= 3'b110;
        end else if (state == WB) begin
            zero_flag <= pend;
            state     <= IDLE;
            alu_func  <= 3'b110;
        end
    end
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (state == WB || (state == EXEC && !is_alu))
            cnt <= cnt + 16'd1;
    end
    assign perf_retired = cnt;
`else
    assign perf_retired = '0;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench for alu_issue_ctrl.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst, instr_valid, alu_zero;
    logic [15:0] instr;
    logic        instr_ready, rf_wr_en, zero_flag, pc_load, illegal;
    logic [2:0]  alu_func, rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
    logic [8:0]  pc_offset;
    logic [15:0] perf_retired;
    int          errors = 0, checks = 0;
    logic [15:0] exp_perf = 16'd0;
    logic        perf_on;

    alu_issue_ctrl #(.N(16), .RA_W(3)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_func(alu_func),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_wr_addr(rf_wr_addr), .rf_wr_en(rf_wr_en), .alu_zero(alu_zero),
        .zero_flag(zero_flag), .pc_load(pc_load), .pc_offset(pc_offset),
        .illegal(illegal), .perf_retired(perf_retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_perf(input string tag);
        chk(tag, perf_retired, perf_on ? exp_perf : 16'd0);
    endtask

    initial begin
`ifdef ALU_ISSUE_PERF_EN
        perf_on = 1'b1;
`else
        perf_on = 1'b0;
`endif
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; alu_zero = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_ready", 16'(instr_ready), 16'd1);
        chk("rst_func", 16'(alu_func), 16'd6);
        chk("rst_zf", 16'(zero_flag), 16'd0);
        chk("rst_wr", 16'(rf_wr_en), 16'd0);
        chk("rst_pcl", 16'(pc_load), 16'd0);
        chk("rst_addr1", 16'(rf_rd_addr1), 16'd0);
        chk("rst_off", 16'(pc_offset), 16'd0);
        chk_perf("rst_perf");

        // ADD r1,r2 with alu_zero=0
        instr = 16'h1280; instr_valid = 1'b1; alu_zero = 1'b0;
        step();
        chk("add_ex_ready", 16'(instr_ready), 16'd0);
        chk("add_ex_func", 16'(alu_func), 16'd1);
        chk("add_ex_a1", 16'(rf_rd_addr1), 16'd1);
        chk("add_ex_a2", 16'(rf_rd_addr2), 16'd2);
        chk("add_ex_wr", 16'(rf_wr_en), 16'd0);
        step();
        chk("add_wb_wr", 16'(rf_wr_en), 16'd1);
        chk("add_wb_wa", 16'(rf_wr_addr), 16'd1);
        chk("add_wb_func", 16'(alu_func), 16'd1);
        chk("add_wb_ready", 16'(instr_ready), 16'd0);
        instr_valid = 1'b0;
        step();
        exp_perf++;
        chk("add_id_ready", 16'(instr_ready), 16'd1);
        chk("add_id_wr", 16'(rf_wr_en), 16'd0);
        chk("add_id_zf", 16'(zero_flag), 16'd0);
        chk("add_id_func", 16'(alu_func), 16'd6);
        chk("add_id_a1_held", 16'(rf_rd_addr1), 16'd1);
        chk_perf("add_perf");

        // BZ +5 with zero_flag=0: no redirect
        instr = 16'h8005; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("bzn_ex_pcl", 16'(pc_load), 16'd0);
        chk("bzn_ex_wr", 16'(rf_wr_en), 16'd0);
        chk("bzn_ex_ready", 16'(instr_ready), 16'd0);
        step();
        exp_perf++;
        chk("bzn_id_ready", 16'(instr_ready), 16'd1);
        chk("bzn_id_zf", 16'(zero_flag), 16'd0);

        // SUB r3,r3 with alu_zero=1
        instr = 16'h26C0; instr_valid = 1'b1; alu_zero = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("sub_ex_func", 16'(alu_func), 16'd2);
        chk("sub_ex_a1", 16'(rf_rd_addr1), 16'd3);
        chk("sub_ex_a2", 16'(rf_rd_addr2), 16'd3);
        step();
        alu_zero = 1'b0;
        chk("sub_wb_wr", 16'(rf_wr_en), 16'd1);
        chk("sub_wb_zf_old", 16'(zero_flag), 16'd0);
        step();
        exp_perf++;
        chk("sub_id_zf", 16'(zero_flag), 16'd1);

        // BZ -4 with zero_flag=1: redirect
        instr = 16'h81FC; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("bz_ex_pcl", 16'(pc_load), 16'd1);
        chk("bz_ex_off", 16'(pc_offset), 16'h1FC);
        chk("bz_ex_wr", 16'(rf_wr_en), 16'd0);
        step();
        exp_perf++;
        chk("bz_id_pcl", 16'(pc_load), 16'd0);
        chk("bz_id_ready", 16'(instr_ready), 16'd1);
        chk("bz_id_zf", 16'(zero_flag), 16'd1);
        chk_perf("bz_perf");

        // illegal opcode then NOP
        instr = 16'hF000; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("ill_ex_ill", 16'(illegal), 16'd1);
        chk("ill_ex_wr", 16'(rf_wr_en), 16'd0);
        step();
        exp_perf++;
        chk("ill_id_ill", 16'(illegal), 16'd0);
        chk("ill_id_ready", 16'(instr_ready), 16'd1);
        instr = 16'h6000; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("nop_ex_ill", 16'(illegal), 16'd0);
        chk("nop_ex_wr", 16'(rf_wr_en), 16'd0);
        chk("nop_ex_func", 16'(alu_func), 16'd6);
        step();
        exp_perf++;
        chk("nop_id_ready", 16'(instr_ready), 16'd1);
        chk("nop_id_zf", 16'(zero_flag), 16'd1);
        chk_perf("nop_perf");

        // AND r0,r1 aborted by rst during WB, valid held high
        instr = 16'h3040; instr_valid = 1'b1; alu_zero = 1'b0;
        step();
        chk("and_ex_func", 16'(alu_func), 16'd3);
        step();
        rst = 1'b1;
        #1;
        chk("and_wb_rst_wr", 16'(rf_wr_en), 16'd0);
        step();
        rst = 1'b0;
        exp_perf = 16'd0;
        chk("and_rst_zf", 16'(zero_flag), 16'd0);
        chk("and_rst_ready", 16'(instr_ready), 16'd1);
        chk("and_rst_func", 16'(alu_func), 16'd6);
        chk_perf("and_rst_perf");
        step();
        chk("and2_ex_ready", 16'(instr_ready), 16'd0);
        instr_valid = 1'b0;
        step();
        chk("and2_wb_wr", 16'(rf_wr_en), 16'd1);
        step();
        exp_perf++;
        chk("and2_id_ready", 16'(instr_ready), 16'd1);
        chk_perf("and2_perf");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
